// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-master UART AXI4-lite arbiter.
// Register offsets are used by the bus masters and by the bench.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_arb_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_RESP
    } wr_arb_state_e;

    localparam int UART_ARB_MASTERS = 2;

    localparam logic [31:0] RX_COUNT = 32'd0;
    localparam logic [31:0] RX_POP   = 32'd8;
    localparam logic [31:0] TX_COUNT = 32'd16;
    localparam logic [31:0] TX_PUSH  = 32'd24;

endpackage

// File: rtl/axil_interface_if.sv
// AXI4-lite bundle with separate read and write views for each side.
// One instance may back both the read and the write port of a master.
interface axil_interface_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport rd_slv (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

    modport rd_mst (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport wr_slv (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport wr_mst (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/uart_arb_rr_pick.sv
// Two-requester picker: on a tie the master not granted last wins,
// unless fixed_prio is set, in which case master 0 always wins.
module uart_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            fixed_prio:          grant = ~req[0];
            !fixed_prio && &req: grant = ~last;
            default:             grant = req[1];
        endcase
    end

endmodule

// File: rtl/uart_axil_arbiter.sv
// Shares the UART AXI4-lite port between two masters, read and write
// arbitrated separately. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_axil_arbiter
    import uart_arb_pkg::*;
#(
    parameter int   NUM_MASTERS = 2,
    parameter logic RR_INIT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    axil_interface_if.rd_slv m0_rd,
    axil_interface_if.wr_slv m0_wr,
    axil_interface_if.rd_slv m1_rd,
    axil_interface_if.wr_slv m1_wr,
    axil_interface_if.rd_mst s_rd,
    axil_interface_if.wr_mst s_wr,
    output logic             rd_grant,
    output logic             wr_grant
);

    if (NUM_MASTERS != UART_ARB_MASTERS) begin : g_num_chk
        $error("uart_axil_arbiter needs exactly 2 masters");
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    rd_arb_state_e rd_state;
    wr_arb_state_e wr_state;
    logic          rd_ptr;
    logic          wr_ptr;
    logic          wr_aw_done;
    logic          wr_w_done;
    logic [1:0]    rd_req;
    logic [1:0]    wr_req;
    logic          rd_pick;
    logic          wr_pick;
    logic          ar_hs;
    logic          r_hs;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;

    assign rd_req = {m1_rd.arvalid, m0_rd.arvalid};
    assign wr_req = {m1_wr.awvalid | m1_wr.wvalid,
                     m0_wr.awvalid | m0_wr.wvalid};

    // The pointer names the favoured master; the picker wants the last one.
    uart_arb_rr_pick u_rd_pick (
        .req        (rd_req),
        .last       (~rd_ptr),
        .fixed_prio (FIXED_PRIO),
        .grant      (rd_pick)
    );

    uart_arb_rr_pick u_wr_pick (
        .req        (wr_req),
        .last       (~wr_ptr),
        .fixed_prio (FIXED_PRIO),
        .grant      (wr_pick)
    );

    always_comb begin
        s_rd.araddr   = rd_grant ? m1_rd.araddr : m0_rd.araddr;
        s_rd.arvalid  = 1'b0;
        s_rd.rready   = 1'b0;
        m0_rd.arready = 1'b0;
        m1_rd.arready = 1'b0;
        m0_rd.rvalid  = 1'b0;
        m1_rd.rvalid  = 1'b0;
        m0_rd.rdata   = s_rd.rdata;
        m1_rd.rdata   = s_rd.rdata;
        m0_rd.rresp   = s_rd.rresp;
        m1_rd.rresp   = s_rd.rresp;
        unique case (rd_state)
            RD_ADDR: begin
                s_rd.arvalid = rd_grant ? m1_rd.arvalid
                                        : m0_rd.arvalid;
                if (rd_grant) m1_rd.arready = s_rd.arready;
                else          m0_rd.arready = s_rd.arready;
            end
            RD_DATA: begin
                s_rd.rready = rd_grant ? m1_rd.rready
                                       : m0_rd.rready;
                if (rd_grant) m1_rd.rvalid = s_rd.rvalid;
                else          m0_rd.rvalid = s_rd.rvalid;
            end
            default: ;
        endcase
    end

    assign ar_hs = s_rd.arvalid && s_rd.arready;
    assign r_hs  = s_rd.rvalid && s_rd.rready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            rd_grant <= 1'b0;
            rd_ptr   <= RR_INIT;
        end else begin
            unique case (rd_state)
                RD_IDLE: if (|rd_req) begin
                    rd_grant <= rd_pick;
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (ar_hs) rd_state <= RD_DATA;
                RD_DATA: if (r_hs) begin
                    rd_state <= RD_IDLE;
                    rd_ptr   <= ~rd_grant;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // A channel that already handshook is masked on both sides.
    always_comb begin
        s_wr.awaddr   = wr_grant ? m1_wr.awaddr : m0_wr.awaddr;
        s_wr.wdata    = wr_grant ? m1_wr.wdata : m0_wr.wdata;
        s_wr.wstrb    = wr_grant ? m1_wr.wstrb : m0_wr.wstrb;
        s_wr.awvalid  = 1'b0;
        s_wr.wvalid   = 1'b0;
        s_wr.bready   = 1'b0;
        m0_wr.awready = 1'b0;
        m1_wr.awready = 1'b0;
        m0_wr.wready  = 1'b0;
        m1_wr.wready  = 1'b0;
        m0_wr.bvalid  = 1'b0;
        m1_wr.bvalid  = 1'b0;
        m0_wr.bresp   = s_wr.bresp;
        m1_wr.bresp   = s_wr.bresp;
        unique case (wr_state)
            WR_ADDR: begin
                s_wr.awvalid = !wr_aw_done &&
                    (wr_grant ? m1_wr.awvalid : m0_wr.awvalid);
                s_wr.wvalid = !wr_w_done &&
                    (wr_grant ? m1_wr.wvalid : m0_wr.wvalid);
                if (wr_grant) begin
                    m1_wr.awready = !wr_aw_done && s_wr.awready;
                    m1_wr.wready  = !wr_w_done && s_wr.wready;
                end else begin
                    m0_wr.awready = !wr_aw_done && s_wr.awready;
                    m0_wr.wready  = !wr_w_done && s_wr.wready;
                end
            end
            WR_RESP: begin
                s_wr.bready = wr_grant ? m1_wr.bready
                                       : m0_wr.bready;
                if (wr_grant) m1_wr.bvalid = s_wr.bvalid;
                else          m0_wr.bvalid = s_wr.bvalid;
            end
            default: ;
        endcase
    end

    assign aw_hs = s_wr.awvalid && s_wr.awready;
    assign w_hs  = s_wr.wvalid && s_wr.wready;
    assign b_hs  = s_wr.bvalid && s_wr.bready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state   <= WR_IDLE;
            wr_grant   <= 1'b0;
            wr_ptr     <= RR_INIT;
            wr_aw_done <= 1'b0;
            wr_w_done  <= 1'b0;
        end else begin
            unique case (wr_state)
                WR_IDLE: if (|wr_req) begin
                    wr_grant <= wr_pick;
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: begin
                    if (aw_hs) wr_aw_done <= 1'b1;
                    if (w_hs)  wr_w_done  <= 1'b1;
                    if ((wr_aw_done || aw_hs) &&
                        (wr_w_done || w_hs))
                        wr_state <= WR_RESP;
                end
                WR_RESP: if (b_hs) begin
                    wr_state   <= WR_IDLE;
                    wr_aw_done <= 1'b0;
                    wr_w_done  <= 1'b0;
                    wr_ptr     <= ~wr_grant;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axil_arbiter.sv
// Scoreboard bench for uart_axil_arbiter with a small UART slave model.
// Expectations follow UART_ARB_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_uart_axil_arbiter;
    import uart_arb_pkg::*;

    localparam int TMO = 200;

    typedef struct packed {
        logic        g;
        logic [31:0] a;
    } a_exp_t;

    typedef struct packed {
        logic        g;
        logic [63:0] d;
    } w_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rd_grant;
    logic wr_grant;

    always #5 clk = ~clk;

    axil_interface_if m0_if ();
    axil_interface_if m1_if ();
    axil_interface_if s_if ();

    uart_axil_arbiter #(
        .NUM_MASTERS (2),
        .RR_INIT     (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_rd    (m0_if),
        .m0_wr    (m0_if),
        .m1_rd    (m1_if),
        .m1_wr    (m1_if),
        .s_rd     (s_if),
        .s_wr     (s_if),
        .rd_grant (rd_grant),
        .wr_grant (wr_grant)
    );

    logic [1:0]  arv;
    logic [1:0]  awv;
    logic [1:0]  wv;
    logic [31:0] ara [2];
    logic [31:0] awa [2];
    logic [63:0] wd  [2];

    assign m0_if.arvalid = arv[0];
    assign m0_if.araddr  = ara[0];
    assign m0_if.rready  = 1'b1;
    assign m0_if.awvalid = awv[0];
    assign m0_if.awaddr  = awa[0];
    assign m0_if.wvalid  = wv[0];
    assign m0_if.wdata   = wd[0];
    assign m0_if.wstrb   = 8'hFF;
    assign m0_if.bready  = 1'b1;
    assign m1_if.arvalid = arv[1];
    assign m1_if.araddr  = ara[1];
    assign m1_if.rready  = 1'b1;
    assign m1_if.awvalid = awv[1];
    assign m1_if.awaddr  = awa[1];
    assign m1_if.wvalid  = wv[1];
    assign m1_if.wdata   = wd[1];
    assign m1_if.wstrb   = 8'hFF;
    assign m1_if.bready  = 1'b1;

    wire [1:0] arr = {m1_if.arready, m0_if.arready};
    wire [1:0] rv  = {m1_if.rvalid, m0_if.rvalid};
    wire [1:0] awr = {m1_if.awready, m0_if.awready};
    wire [1:0] wr  = {m1_if.wready, m0_if.wready};
    wire [1:0] bv  = {m1_if.bvalid, m0_if.bvalid};

    wire [14:0] dut_hs = {
        s_if.arvalid, s_if.rready, s_if.awvalid,
        s_if.wvalid, s_if.bready,
        m0_if.arready, m0_if.rvalid, m0_if.awready,
        m0_if.wready, m0_if.bvalid,
        m1_if.arready, m1_if.rvalid, m1_if.awready,
        m1_if.wready, m1_if.bvalid
    };

    // UART slave: RX_POP returns an incrementing byte from 0x41.
    logic       r_hold;
    logic       s_wready;
    logic [7:0] pop_ctr;
    logic       aw_got;
    logic       w_got;

    assign s_if.arready = 1'b1;
    assign s_if.awready = 1'b1;
    assign s_if.wready  = s_wready;
    assign s_if.rresp   = 2'b00;
    assign s_if.bresp   = 2'b00;

    wire s_awhs = s_if.awvalid && s_if.awready;
    wire s_whs  = s_if.wvalid && s_if.wready;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_if.rvalid <= 1'b0;
            s_if.rdata  <= '0;
            s_if.bvalid <= 1'b0;
            pop_ctr     <= 8'h41;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
        end else begin
            if (s_if.arvalid && s_if.arready) begin
                s_if.rvalid <= !r_hold;
                if (s_if.araddr == RX_POP) begin
                    s_if.rdata <= {56'h0, pop_ctr};
                    pop_ctr    <= pop_ctr + 8'd1;
                end else if (s_if.araddr == RX_COUNT) begin
                    s_if.rdata <= 64'h10;
                end else begin
                    s_if.rdata <= '0;
                end
            end else if (s_if.rvalid && s_if.rready) begin
                s_if.rvalid <= 1'b0;
            end
            if (s_if.bvalid && s_if.bready)
                s_if.bvalid <= 1'b0;
            if ((aw_got || s_awhs) && (w_got || s_whs)) begin
                s_if.bvalid <= 1'b1;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
            end else begin
                if (s_awhs) aw_got <= 1'b1;
                if (s_whs)  w_got  <= 1'b1;
            end
        end
    end

    a_exp_t      exp_ar [$];
    a_exp_t      exp_aw [$];
    w_exp_t      exp_w  [$];
    logic [63:0] exp_r0 [$];
    logic [63:0] exp_r1 [$];
    int exp_b0 = 0;
    int exp_b1 = 0;
    int checks = 0;
    int failures = 0;
    int ar_count = 0;
    int aw_count = 0;
    int w_count = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h",
                     nm, act, exp);
        end
    endtask

    task automatic to_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got no handshake, required one within %0d cycles",
                 nm, TMO);
    endtask

    task automatic push_ar(input logic g, input logic [31:0] a);
        exp_ar.push_back('{g: g, a: a});
    endtask

    // Monitor: every DUT handshake pops and checks one expectation.
    always @(negedge clk) begin
        a_exp_t ea;
        w_exp_t ew;
        if (rst) begin
            if (s_if.arvalid && s_if.arready) begin
                ar_count++;
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("ar_grant", rd_grant, ea.g);
                    chk("ar_addr", s_if.araddr, ea.a);
                end
            end
            if (|rv)
                chk("r_owner", rv, rd_grant ? 2'b10 : 2'b01);
            if (m0_if.rvalid && m0_if.rready) begin
                if (exp_r0.size() == 0) chk("r0_unexpected", 1, 0);
                else chk("r0_data", m0_if.rdata, exp_r0.pop_front());
            end
            if (m1_if.rvalid && m1_if.rready) begin
                if (exp_r1.size() == 0) chk("r1_unexpected", 1, 0);
                else chk("r1_data", m1_if.rdata, exp_r1.pop_front());
            end
            if (s_awhs) begin
                aw_count++;
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 1, 0);
                end else begin
                    ea = exp_aw.pop_front();
                    chk("aw_grant", wr_grant, ea.g);
                    chk("aw_addr", s_if.awaddr, ea.a);
                end
            end
            if (s_whs) begin
                w_count++;
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 1, 0);
                end else begin
                    ew = exp_w.pop_front();
                    chk("w_grant", wr_grant, ew.g);
                    chk("w_data", s_if.wdata, ew.d);
                end
            end
            if (|bv)
                chk("b_owner", bv, wr_grant ? 2'b10 : 2'b01);
            if (m0_if.bvalid && m0_if.bready) begin
                if (exp_b0 == 0) chk("b0_unexpected", 1, 0);
                else exp_b0--;
            end
            if (m1_if.bvalid && m1_if.bready) begin
                if (exp_b1 == 0) chk("b1_unexpected", 1, 0);
                else exp_b1--;
            end
        end
    end

    task automatic do_read(input int m, input logic [31:0] a);
        int n;
        arv[m] = 1'b1;
        ara[m] = a;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!arr[m] && n < TMO);
        if (!arr[m]) to_fail("ar_wait");
        @(posedge clk);
        #1 arv[m] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!rv[m] && n < TMO);
        if (!rv[m]) to_fail("r_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int m, input logic [31:0] a,
                            input logic [63:0] d, input int wdly);
        int n;
        fork
            begin
                int na;
                awv[m] = 1'b1;
                awa[m] = a;
                na = 0;
                do begin @(negedge clk); na++; end
                while (!awr[m] && na < TMO);
                if (!awr[m]) to_fail("aw_wait");
                @(posedge clk);
                #1 awv[m] = 1'b0;
            end
            begin
                int nw;
                repeat (wdly) @(posedge clk);
                #1;
                wv[m] = 1'b1;
                wd[m] = d;
                nw = 0;
                do begin @(negedge clk); nw++; end
                while (!wr[m] && nw < TMO);
                if (!wr[m]) to_fail("w_wait");
                @(posedge clk);
                #1 wv[m] = 1'b0;
            end
        join
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bv[m] && n < TMO);
        if (!bv[m]) to_fail("b_wait");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required one before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        logic held;
        logic g;
        arv = '0;
        awv = '0;
        wv = '0;
        for (int i = 0; i < 2; i++) begin
            ara[i] = '0;
            awa[i] = '0;
            wd[i] = '0;
        end
        r_hold = 1'b0;
        s_wready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_handshakes", dut_hs, 0);
        chk("reset_grants", {rd_grant, wr_grant}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Read abandoned by reset while in RD_DATA
        r_hold = 1'b1;
        push_ar(1'b0, RX_POP);
        arv[0] = 1'b1;
        ara[0] = RX_POP;
        @(negedge clk);
        chk("ar_latency_c0", s_if.arvalid, 0);
        @(negedge clk);
        chk("ar_latency_c1", s_if.arvalid, 1);
        @(posedge clk);
        #1 arv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_read_in_data", {s_if.rready, rd_grant}, 2'b10);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("mid_rst_handshakes", dut_hs, 0);
        @(negedge clk);
        chk("mid_rst_handshakes_next", dut_hs, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        r_hold = 1'b0;
        c0 = ar_count;
        push_ar(1'b1, RX_COUNT);
        exp_r1.push_back(64'h10);
        do_read(1, RX_COUNT);
        chk("post_rst_ar_count", ar_count - c0, 1);

        // Simultaneous RX_POP reads
        c0 = ar_count;
        push_ar(1'b0, RX_POP);
        push_ar(1'b1, RX_POP);
        exp_r0.push_back(64'h41);
        exp_r1.push_back(64'h42);
        fork
            do_read(0, RX_POP);
            do_read(1, RX_POP);
        join
        chk("tie_ar_count", ar_count - c0, 2);

        // Back-to-back m0 against a waiting m1
        c0 = ar_count;
        for (int k = 0; k < 8; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            g = (k >= 4);
`else
            g = k[0];
`endif
            push_ar(g, RX_POP);
            if (g) exp_r1.push_back(64'h43 + 64'(k));
            else   exp_r0.push_back(64'h43 + 64'(k));
        end
        fork
            begin repeat (4) do_read(0, RX_POP); end
            begin repeat (4) do_read(1, RX_POP); end
        join
        chk("stream_ar_count", ar_count - c0, 8);

        // Split AW/W from m1
        c0 = aw_count;
        c1 = w_count;
        exp_aw.push_back('{g: 1'b1, a: TX_PUSH});
        exp_w.push_back('{g: 1'b1, d: 64'h41});
        exp_b1++;
        do_write(1, TX_PUSH, 64'h41, 3);
        chk("split_aw_count", aw_count - c0, 1);
        chk("split_w_count", w_count - c1, 1);

        // TX buffer full while m0 owns the write channel
        s_wready = 1'b0;
        exp_aw.push_back('{g: 1'b0, a: TX_PUSH});
        exp_aw.push_back('{g: 1'b1, a: TX_PUSH});
        exp_w.push_back('{g: 1'b0, d: 64'h42});
        exp_w.push_back('{g: 1'b1, d: 64'h43});
        exp_b0++;
        exp_b1++;
        fork
            do_write(0, TX_PUSH, 64'h42, 0);
            begin
                repeat (2) @(posedge clk);
                #1 do_write(1, TX_PUSH, 64'h43, 0);
            end
            begin
                repeat (2) @(posedge clk);
                held = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (wr_grant !== 1'b0 || s_if.wvalid !== 1'b1 ||
                        m1_if.awready || m1_if.wready)
                        held = 1'b0;
                end
                chk("txfull_grant_held", held, 1);
                @(posedge clk);
                #1 s_wready = 1'b1;
            end
        join

        // Read and write from different masters together
        push_ar(1'b0, RX_COUNT);
        exp_r0.push_back(64'h10);
        exp_aw.push_back('{g: 1'b1, a: TX_PUSH});
        exp_w.push_back('{g: 1'b1, d: 64'h44});
        exp_b1++;
        fork
            do_read(0, RX_COUNT);
            do_write(1, TX_PUSH, 64'h44, 1);
        join

        repeat (3) @(posedge clk);
        chk("scoreboard_drained",
            exp_ar.size() + exp_aw.size() + exp_w.size() +
            exp_r0.size() + exp_r1.size() + exp_b0 + exp_b1, 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
